pe_conv_kx: RTL and testbench

Streaming KxK convolution processing element. It is the parametrised successor of the fixed 3x3 PE: kernel size, line length and channel count are parameters, and it adds bias, saturation and a frame-aware window-valid generator. Pixels arrive one per accepted cycle, raster order, with CL_IN channels in parallel. Each PE produces one N-bit output feature per complete window. Weights are daisy-chained between PEs through w_in/w_out.

---
 rtl/pe_pkg.sv | 40 ++++
 rtl/pe_conv_kx_if.sv | 16 +
 rtl/pe_line_buf.sv | 23 ++
 rtl/pe_conv_kx.sv | 180 ++++++++++++++++++
 tb/tb_pe_conv_kx.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/pe_pkg.sv
// Shared helpers for the KxK convolution PE: width math, tap ordering,
// output clamping and kernel-size legality.
package pe_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r = r + 1;
    return r;
  endfunction

  // Accumulator wide enough for every product plus the bias without overflow.
  function automatic int unsigned acc_w(input int unsigned n, input int unsigned m,
                                        input int unsigned taps);
    return n + m + clog2(taps + 1);
  endfunction

  // Chain position of the weight for channel c, row r (0 = oldest), column k (0 = oldest).
  function automatic int unsigned tap_idx(input int unsigned c, input int unsigned r,
                                          input int unsigned k, input int unsigned kern);
    return c * kern * kern + r * kern + k;
  endfunction

  function automatic logic signed [63:0] sat_relu(input logic signed [63:0] v,
                                                  input int unsigned n, input logic relu);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (n - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (n - 1));
    if (relu && (v < 64'sd0)) return 64'sd0;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic bit kernel_ok(input int unsigned k);
    return (k == 1) || (k == 3) || (k == 5) || (k == 7);
  endfunction

endpackage

// File: rtl/pe_conv_kx_if.sv
// Pixel stream in / feature stream out of one convolution PE.
interface pe_conv_kx_if #(
  parameter int unsigned CL_IN = 4,
  parameter int unsigned N     = 2
) ();
  logic [CL_IN*N-1:0] d_in;
  logic               d_valid;
  logic               frame_start;
  logic [N-1:0]       d_out;
  logic               en_out;

  modport master (output d_in, output d_valid, output frame_start,
                  input d_out, input en_out);
  modport slave  (input d_in, input d_valid, input frame_start,
                  output d_out, output en_out);
endinterface

// File: rtl/pe_line_buf.sv
// One image row of delay; advances only when a pixel is accepted.
module pe_line_buf #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      mem_q[0] <= d;
      for (int i = 1; i < DEPTH; i++) mem_q[i] <= mem_q[i-1];
    end
  end

  assign q = mem_q[DEPTH-1];

endmodule

// File: rtl/pe_conv_kx.sv
// Streaming KxK convolution PE: line buffers, window, multiply, adder tree
// with bias, shift/ReLU/saturate, plus a registered single-channel bypass.
module pe_conv_kx import pe_pkg::*; #(
  parameter int unsigned LINES  = 16,
  parameter int unsigned CL_IN  = 4,
  parameter int unsigned CL1    = 2,
  parameter int unsigned KERNEL = 3,
  parameter int unsigned N      = 2,
  parameter int unsigned M      = 4,
  parameter int unsigned SR     = 2
) (
  input  logic                clk,
  input  logic                rst,
  pe_conv_kx_if.slave         px,
  input  logic                w_conf,
  input  logic signed [M-1:0] w_in,
  output logic signed [M-1:0] w_out,
  input  logic                cntl_conf,
  input  logic                relu_in,
  input  logic                bp_en_in,
  input  logic [CL1-1:0]      bp_src_in
);

  localparam int unsigned KK   = KERNEL * KERNEL;
  localparam int unsigned TAPS = CL_IN * KK;
  localparam int unsigned W    = TAPS + 1;
  localparam int unsigned PW   = N + M;
  localparam int unsigned AW   = acc_w(N, M, TAPS);
  localparam int unsigned DW   = CL_IN * N;
  localparam int unsigned CW   = (clog2(LINES) < 1) ? 1 : clog2(LINES);
  localparam int unsigned RW   = (clog2(KERNEL) < 1) ? 1 : clog2(KERNEL);
  localparam int unsigned LBN  = (KERNEL > 1) ? KERNEL - 1 : 1;

  if (!kernel_ok(KERNEL)) begin : g_bad_kernel
    $error("pe_conv_kx: KERNEL must be 1, 3, 5 or 7");
  end

  logic signed [M-1:0]  chain_q [W];
  logic                 relu_q, bp_en_q;
  logic [CL1-1:0]       bp_src_q;
  logic [CW-1:0]        col_q, pos_col_c;
  logic [RW-1:0]        row_q, pos_row_c;
  logic                 accept_c, complete_c;
  logic [DW-1:0]        lb_q [LBN];
  logic [DW-1:0]        row_src [KERNEL];
  logic [DW-1:0]        win_q [KERNEL][KERNEL];
  logic signed [PW-1:0] prod_c [TAPS];
  logic signed [PW-1:0] prod_q [TAPS];
  logic signed [AW-1:0] acc_c, acc_q, shifted_c;
  logic [N-1:0]         res_c;
  logic                 v1_q, v2_q, v3_q;

  // Weight chain: taps at 0..W-2, bias at W-1 (first word shifted in).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < W; i++) chain_q[i] <= '0;
    end else if (w_conf) begin
      chain_q[0] <= w_in;
      for (int i = 1; i < W; i++) chain_q[i] <= chain_q[i-1];
    end
  end

  assign w_out = chain_q[W-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      relu_q   <= 1'b0;
      bp_en_q  <= 1'b0;
      bp_src_q <= '0;
    end else if (cntl_conf) begin
      relu_q   <= relu_in;
      bp_en_q  <= bp_en_in;
      bp_src_q <= bp_src_in;
    end
  end

  // Position of the pixel being presented; frame_start forces it to the origin.
  always_comb begin
    accept_c  = px.d_valid && !w_conf;
    pos_col_c = col_q;
    pos_row_c = row_q;
    if (px.frame_start) begin
      pos_col_c = '0;
      pos_row_c = '0;
    end
    complete_c = (pos_col_c >= CW'(KERNEL - 1)) && (pos_row_c >= RW'(KERNEL - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q <= '0;
      row_q <= '0;
    end else if (accept_c) begin
      if (pos_col_c == CW'(LINES - 1)) begin
        col_q <= '0;
        row_q <= (pos_row_c == RW'(KERNEL - 1)) ? pos_row_c : pos_row_c + RW'(1);
      end else begin
        col_q <= pos_col_c + CW'(1);
        row_q <= pos_row_c;
      end
    end
  end

  for (genvar j = 0; j < KERNEL - 1; j++) begin : g_lb
    if (j == 0) begin : g_first
      pe_line_buf #(.DEPTH(LINES), .WIDTH(DW)) u_lb (
        .clk(clk), .en(accept_c), .d(px.d_in), .q(lb_q[j]));
    end else begin : g_next
      pe_line_buf #(.DEPTH(LINES), .WIDTH(DW)) u_lb (
        .clk(clk), .en(accept_c), .d(lb_q[j-1]), .q(lb_q[j]));
    end
  end

  // Row 0 is the oldest row (deepest line buffer), row K-1 is the live pixel.
  for (genvar r = 0; r < KERNEL; r++) begin : g_row
    if (r == KERNEL - 1) begin : g_live
      assign row_src[r] = px.d_in;
    end else begin : g_old
      assign row_src[r] = lb_q[KERNEL-2-r];
    end
  end

  always_ff @(posedge clk) begin
    if (accept_c) begin
      for (int r = 0; r < KERNEL; r++) begin
        for (int k = 0; k < KERNEL - 1; k++) win_q[r][k] <= win_q[r][k+1];
        win_q[r][KERNEL-1] <= row_src[r];
      end
    end
  end

  always_comb begin
    for (int t = 0; t < TAPS; t++) prod_c[t] = '0;
    for (int c = 0; c < CL_IN; c++)
      for (int r = 0; r < KERNEL; r++)
        for (int k = 0; k < KERNEL; k++)
          prod_c[tap_idx(c, r, k, KERNEL)] =
            PW'($signed(win_q[r][k][c*N +: N])) * PW'(chain_q[tap_idx(c, r, k, KERNEL)]);
  end

  always_comb begin
    acc_c = AW'(chain_q[W-1]);
    for (int t = 0; t < TAPS; t++) acc_c = acc_c + AW'(prod_q[t]);
  end

  always_ff @(posedge clk) begin
    for (int t = 0; t < TAPS; t++) prod_q[t] <= prod_c[t];
    acc_q <= acc_c;
  end

  assign shifted_c = acc_q >>> SR;
  assign res_c     = N'(sat_relu(64'(shifted_c), N, relu_q));

  // Window valids; bypass mode kills anything in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else begin
      v1_q <= accept_c && complete_c && !bp_en_q;
      v2_q <= v1_q && !bp_en_q;
      v3_q <= v2_q && !bp_en_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      px.en_out <= 1'b0;
      px.d_out  <= '0;
    end else if (bp_en_q) begin
      px.en_out <= accept_c;
      if (accept_c) px.d_out <= px.d_in[32'(bp_src_q)*N +: N];
    end else begin
      px.en_out <= v3_q;
      if (v3_q) px.d_out <= res_c;
    end
  end

endmodule

// File: tb/tb_pe_conv_kx.sv
// Directed self-checking bench for pe_conv_kx with default parameters.
module tb_pe_conv_kx;

  logic              clk = 1'b0;
  logic              rst;
  logic              w_conf;
  logic signed [3:0] w_in;
  logic signed [3:0] w_out;
  logic              cntl_conf;
  logic              relu_in;
  logic              bp_en_in;
  logic [1:0]        bp_src_in;
  int                checks = 0;
  int                errors = 0;

  always #5 clk = ~clk;

  pe_conv_kx_if #(.CL_IN(4), .N(2)) px ();

  pe_conv_kx dut (
    .clk(clk), .rst(rst), .px(px),
    .w_conf(w_conf), .w_in(w_in), .w_out(w_out),
    .cntl_conf(cntl_conf), .relu_in(relu_in),
    .bp_en_in(bp_en_in), .bp_src_in(bp_src_in)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_word(input logic [3:0] w);
    w_conf = 1'b1;
    w_in   = w;
    tick();
    w_conf = 1'b0;
  endtask

  task automatic load_uniform(input logic [3:0] tap, input logic [3:0] bias);
    shift_word(bias);
    repeat (36) shift_word(tap);
  endtask

  task automatic configure(input logic relu, input logic bp, input logic [1:0] src);
    cntl_conf = 1'b1;
    relu_in   = relu;
    bp_en_in  = bp;
    bp_src_in = src;
    tick();
    cntl_conf = 1'b0;
  endtask

  task automatic feed_pixels(input int n, input logic [7:0] din, input bit fs);
    for (int i = 0; i < n; i++) begin
      px.d_valid     = 1'b1;
      px.frame_start = fs && (i == 0);
      px.d_in        = din;
      tick();
    end
    px.d_valid     = 1'b0;
    px.frame_start = 1'b0;
  endtask

  // One 16x16 frame of all -1 pixels; reports en_out count, wrong d_out count and latency.
  task automatic run_frame(input bit gaps, input logic [1:0] exp_d,
                           output int n_en, output int n_bad, output int lat);
    int n_acc;
    int i35;
    int first;
    int span;
    n_acc = 0; i35 = -1; first = -1; n_en = 0; n_bad = 0;
    span  = gaps ? 512 : 256;
    for (int i = 0; i < span + 8; i++) begin
      logic v;
      v = (i < span) && (!gaps || (i % 2 == 0));
      px.d_valid     = v;
      px.frame_start = v && (n_acc == 0);
      px.d_in        = 8'hFF;
      tick();
      if (v) begin
        n_acc++;
        if (n_acc == 35) i35 = i;
      end
      if (px.en_out) begin
        n_en++;
        if (first < 0) first = i;
        if (px.d_out !== exp_d) n_bad++;
      end
    end
    px.d_valid     = 1'b0;
    px.frame_start = 1'b0;
    lat = first - i35;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    checks++; if (px.en_out !== 1'b0) begin errors++; $display("FAIL reset_en_out got %0b want 0", px.en_out); end
    checks++; if (px.d_out !== 2'b00) begin errors++; $display("FAIL reset_d_out got %0b want 00", px.d_out); end
    checks++; if (w_out !== 4'sd0) begin errors++; $display("FAIL reset_w_out got %0d want 0", w_out); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_chain();
    logic [3:0] exp_w;
    for (int i = 0; i < 37; i++) shift_word(4'(i));
    checks++; if (w_out !== 4'sd0) begin errors++; $display("FAIL chain_w_out_0 got %0d want 0", w_out); end
    for (int j = 1; j < 37; j++) begin
      shift_word(4'(j));
      exp_w = 4'(j);
      checks++;
      if (w_out !== exp_w) begin
        errors++; $display("FAIL chain_w_out_%0d got %0h want %0h", j, w_out, exp_w);
      end
    end
  endtask

  // Bias -4 plus a single weight 7 at tap c=1,r=0,k=0 (chain index 9, word 27).
  task automatic test_taps();
    int ne;
    ne = 0;
    for (int k = 0; k < 37; k++) shift_word((k == 0) ? 4'hC : ((k == 27) ? 4'h7 : 4'h0));
    for (int i = 0; i < 46; i++) begin
      px.d_valid     = (i < 40);
      px.frame_start = (i == 0);
      px.d_in        = (i == 0) ? 8'h04 : 8'h00;
      tick();
      if (px.en_out) begin
        if (ne == 0) begin
          checks++; if (px.d_out !== 2'b00) begin errors++; $display("FAIL taps_first_window got %0b want 00", px.d_out); end
        end else if (ne == 1) begin
          checks++; if (px.d_out !== 2'b11) begin errors++; $display("FAIL taps_bias_only got %0b want 11", px.d_out); end
        end
        ne++;
      end
    end
    px.d_valid = 1'b0; px.frame_start = 1'b0;
    checks++; if (ne !== 6) begin errors++; $display("FAIL taps_en_count got %0d want 6", ne); end
  endtask

  task automatic test_saturation();
    int n_en, n_bad, lat;
    load_uniform(4'h7, 4'h0);
    run_frame(1'b0, 2'b10, n_en, n_bad, lat);
    checks++; if (n_en !== 196) begin errors++; $display("FAIL sat_en_count got %0d want 196", n_en); end
    checks++; if (n_bad !== 0) begin errors++; $display("FAIL sat_d_out_wrong got %0d want 0", n_bad); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL sat_latency got %0d want 3", lat); end
  endtask

  task automatic test_relu();
    int n_en, n_bad, lat;
    configure(1'b1, 1'b0, 2'd0);
    run_frame(1'b0, 2'b00, n_en, n_bad, lat);
    checks++; if (n_en !== 196) begin errors++; $display("FAIL relu_en_count got %0d want 196", n_en); end
    checks++; if (n_bad !== 0) begin errors++; $display("FAIL relu_d_out_wrong got %0d want 0", n_bad); end
  endtask

  task automatic test_bypass();
    logic       tv   [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [7:0] tdin [6] = '{8'b11_10_01_00, 8'b00_01_00_00, 8'b00_01_00_00,
                             8'b00_11_00_00, 8'b00_00_00_00, 8'b00_00_11_11};
    logic [1:0] tdo  [6] = '{2'b10, 2'b10, 2'b01, 2'b11, 2'b11, 2'b00};
    int seen;
    configure(1'b0, 1'b0, 2'd0);
    feed_pixels(34, 8'hFF, 1'b1);
    px.d_valid = 1'b1; px.d_in = 8'hFF;
    tick();
    px.d_valid = 1'b0;
    configure(1'b0, 1'b1, 2'd2);
    seen = px.en_out ? 1 : 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (px.en_out) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL bypass_drop_inflight got %0d want 0", seen); end
    for (int i = 0; i < 6; i++) begin
      px.d_valid = tv[i];
      px.d_in    = tdin[i];
      tick();
      checks++; if (px.en_out !== tv[i]) begin errors++; $display("FAIL bypass_en_%0d got %0b want %0b", i, px.en_out, tv[i]); end
      checks++; if (px.d_out !== tdo[i]) begin errors++; $display("FAIL bypass_d_%0d got %0b want %0b", i, px.d_out, tdo[i]); end
    end
    px.d_valid = 1'b0;
    configure(1'b0, 1'b0, 2'd0);
  endtask

  task automatic test_gaps();
    int n_en, n_bad, lat;
    feed_pixels(5, 8'hFF, 1'b0);
    repeat (8) tick();
    run_frame(1'b1, 2'b10, n_en, n_bad, lat);
    checks++; if (n_en !== 196) begin errors++; $display("FAIL gaps_en_count got %0d want 196", n_en); end
    checks++; if (n_bad !== 0) begin errors++; $display("FAIL gaps_d_out_wrong got %0d want 0", n_bad); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL gaps_latency got %0d want 3", lat); end
  endtask

  task automatic test_reset_mid();
    int n_en, n_bad, lat, seen;
    load_uniform(4'h7, 4'h1);
    checks++; if (w_out !== 4'sd1) begin errors++; $display("FAIL mid_w_out_loaded got %0d want 1", w_out); end
    feed_pixels(36, 8'hFF, 1'b1);
    #2 rst = 1'b0;
    #1;
    checks++; if (px.en_out !== 1'b0) begin errors++; $display("FAIL mid_rst_en_out got %0b want 0", px.en_out); end
    checks++; if (px.d_out !== 2'b00) begin errors++; $display("FAIL mid_rst_d_out got %0b want 00", px.d_out); end
    checks++; if (w_out !== 4'sd0) begin errors++; $display("FAIL mid_rst_w_out got %0d want 0", w_out); end
    repeat (2) tick();
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (px.en_out) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL mid_rst_no_inflight got %0d want 0", seen); end
    run_frame(1'b0, 2'b00, n_en, n_bad, lat);
    checks++; if (n_en !== 196) begin errors++; $display("FAIL mid_post_en_count got %0d want 196", n_en); end
    checks++; if (n_bad !== 0) begin errors++; $display("FAIL mid_post_nonzero got %0d want 0", n_bad); end
  endtask

  initial begin
    rst = 1'b0; w_conf = 1'b0; w_in = '0; cntl_conf = 1'b0;
    relu_in = 1'b0; bp_en_in = 1'b0; bp_src_in = '0;
    px.d_in = '0; px.d_valid = 1'b0; px.frame_start = 1'b0;
    test_reset();
    test_chain();
    test_taps();
    test_saturation();
    test_relu();
    test_bypass();
    test_gaps();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
